// File: rtl/eprisc_bus_pkg.sv
// Shared types and constants for the epRISC peripheral-bus master.
package eprisc_bus_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] SEL_NONE      = 2'd0;
  localparam logic [1:0] LEN_CODE_FULL = 2'd0;
  localparam logic [2:0] LEN_FULL      = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_TAIL,
    ST_DONE
  } state_t;

  // Length code 0 encodes a full word; 1..3 are literal byte counts.
  function automatic logic [2:0] len_decode(input logic [1:0] code);
    return (code == LEN_CODE_FULL) ? LEN_FULL : {1'b0, code};
  endfunction

endpackage

// File: rtl/eprisc_bus_master_if.sv
// Core-request and bus-pin bundle for the epRISC bus master.
interface eprisc_bus_master_if;
  import eprisc_bus_pkg::*;

  logic                iStart;
  logic [1:0]          iDevice;
  logic [1:0]          iLength;
  logic [WORD_W-1:0]   iData;
  logic                oBusy;
  logic                oDone;
  logic                oError;
  logic [WORD_W-1:0]   oRead;
  logic                oInterrupt;
  logic [BYTE_W-1:0]   oBusMOSI;
  logic [BYTE_W-1:0]   iBusMISO;
  logic                oBusClock;
  logic [1:0]          oBusSelect;
  logic                iBusInterrupt;

  modport master (
    input  iStart, iDevice, iLength, iData, iBusMISO, iBusInterrupt,
    output oBusy, oDone, oError, oRead, oInterrupt, oBusMOSI, oBusClock, oBusSelect
  );

  modport slave (
    output iStart, iDevice, iLength, iData, iBusMISO, iBusInterrupt,
    input  oBusy, oDone, oError, oRead, oInterrupt, oBusMOSI, oBusClock, oBusSelect
  );

endinterface

// File: rtl/eprisc_bus_phase.sv
// Loadable down-counter; o_tick marks the last cycle of a bus-clock phase.
module eprisc_bus_phase #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/eprisc_bus_master.sv
// epRISC peripheral-bus master: serialises 1-4 byte transfers onto the
// 8-bit parallel bus and collects MISO bytes into a right-justified word.
module eprisc_bus_master
  import eprisc_bus_pkg::*;
#(
  parameter int unsigned CLKDIV      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 iBoardClock,
  input  logic                 iBoardReset,
  eprisc_bus_master_if.master  bus
);

  localparam logic [7:0] PH_HALF = 8'(CLKDIV - 1);
  // Tail phase is one cycle longer than a half-period, giving the
  // CLKDIV+1 select hold after the final falling edge.
  localparam logic [7:0] PH_TAIL = 8'(CLKDIV);

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_dev;
  logic [2:0]              r_rem;
  logic [WORD_W-1:0]       r_shift;
  logic [WORD_W-1:0]       r_rx;
  logic [WORD_W-1:0]       r_read;
  logic                    r_err;
  logic [SYNC_STAGES-1:0]  r_sync;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_illegal;
  logic                    w_active;
  logic                    w_tick;
  logic                    w_load;
  logic                    w_last;
  logic [7:0]              w_load_val;
  logic [2:0]              w_len;
  logic [2:0]              w_pad;

  assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept   = w_ready && bus.iStart && (bus.iDevice != SEL_NONE);
  assign w_illegal  = w_ready && bus.iStart && (bus.iDevice == SEL_NONE);
  assign w_active   = (r_state == ST_LOW) || (r_state == ST_HIGH) || (r_state == ST_TAIL);
  assign w_last     = (r_rem == 3'd1);
  assign w_load     = w_accept || (w_active && w_tick);
  assign w_load_val = (r_state == ST_HIGH && w_last) ? PH_TAIL : PH_HALF;
  assign w_len      = len_decode(bus.iLength);
  assign w_pad      = LEN_FULL - w_len;

  eprisc_bus_phase #(.W(8)) u_phase (
    .i_clk   (iBoardClock),
    .i_rst   (iBoardReset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_tick  (w_tick)
  );

  // State register.
  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  // Next-state logic; DONE accepts a new request exactly like IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: w_next = w_accept ? ST_LOW : ST_IDLE;
      ST_LOW:           if (w_tick) w_next = ST_HIGH;
      ST_HIGH:          if (w_tick) w_next = w_last ? ST_TAIL : ST_LOW;
      ST_TAIL:          if (w_tick) w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  // Transfer datapath: request latch, TX byte shifter, RX capture.
  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) begin
      r_dev   <= SEL_NONE;
      r_rem   <= '0;
      r_shift <= '0;
      r_rx    <= '0;
      r_read  <= '0;
    end else if (w_accept) begin
      r_dev   <= bus.iDevice;
      r_rem   <= w_len;
      // Left-align the N payload bytes so the top byte is always on the pins.
      r_shift <= bus.iData << {w_pad, 3'b000};
      r_rx    <= '0;
    end else if (w_tick) begin
      case (r_state)
        ST_LOW:  r_rx <= {r_rx[WORD_W-BYTE_W-1:0], bus.iBusMISO};
        ST_HIGH: if (!w_last) begin
                   r_shift <= r_shift << BYTE_W;
                   r_rem   <= r_rem - 3'd1;
                 end
        ST_TAIL: r_read <= r_rx;
        default: ;
      endcase
    end
  end

  // Illegal-select pulse, one cycle after the request.
  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) r_err <= 1'b0;
    else             r_err <= w_illegal;
  end

  // Interrupt synchroniser, independent of the transfer FSM.
  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) r_sync <= '0;
    else             r_sync <= {r_sync[SYNC_STAGES-2:0], bus.iBusInterrupt};
  end

  // Output decode from state and datapath registers.
  always_comb begin
    bus.oBusy      = 1'b0;
    bus.oDone      = 1'b0;
    bus.oBusClock  = 1'b0;
    bus.oBusSelect = SEL_NONE;
    bus.oBusMOSI   = '0;
    bus.oError     = r_err;
    bus.oRead      = r_read;
    bus.oInterrupt = r_sync[SYNC_STAGES-1];
    case (r_state)
      ST_LOW, ST_TAIL: begin
        bus.oBusy      = 1'b1;
        bus.oBusSelect = r_dev;
        bus.oBusMOSI   = r_shift[WORD_W-1 -: BYTE_W];
      end
      ST_HIGH: begin
        bus.oBusy      = 1'b1;
        bus.oBusClock  = 1'b1;
        bus.oBusSelect = r_dev;
        bus.oBusMOSI   = r_shift[WORD_W-1 -: BYTE_W];
      end
      ST_DONE: bus.oDone = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/eprisc_bus_master.md
Name: eprisc_bus_master

Overview:
- Peripheral-bus master inside the epRISC machine, between the core's I/O register port and the external 8-bit parallel bus pins (oBusMOSI, iBusMISO, oBusClock, oBusSelect, iBusInterrupt).
- Takes a 1–4 byte transfer request from the core, serialises it byte-by-byte onto the bus, and captures MISO bytes into a read word.
- Synchronises the bus interrupt line for the core.

Parameters:
- CLKDIV, 4: system clocks per bus-clock half-period; legal range 1..255.
- SYNC_STAGES, 2: flip-flop stages on iBusInterrupt; minimum 2.

Ports:
- iBoardClock  in  1  system clock; all logic on the rising edge.
- iBoardReset  in  1  asynchronous, active-high reset.
- iStart  in  1  transfer request; sampled only when oBusy=0.
- iDevice  in  2  target select; 1..3 valid, 0 = illegal.
- iLength  in  2  byte count; 1..3 as-is, 0 means 4.
- iData  in  32  write word; the low N bytes are sent, most significant of them first.
- oBusy  out  1  high while a transfer is in progress.
- oDone  out  1  single-cycle pulse at transfer end.
- oError  out  1  single-cycle pulse when iDevice=0 is requested.
- oRead  out  32  received bytes, right-justified, zero-filled; valid from oDone onward, held until the next accepted start.
- oInterrupt  out  1  synchronised iBusInterrupt (level).
- oBusMOSI  out  8  bus data out.
- iBusMISO  in  8  bus data in.
- oBusClock  out  1  bus clock.
- oBusSelect  out  2  device select; 0 = none.

Behaviour:
- Reset (async, immediate, including mid-transfer): oBusy=0, oDone=0, oError=0, oRead=0, oInterrupt=0, oBusMOSI=0, oBusClock=0, oBusSelect=0, all sync stages cleared, FSM to IDLE.
- States:
  - IDLE: on iStart=1 with iDevice=0, pulse oError next cycle and stay in IDLE. On iStart=1 with iDevice≠0, go to LOW and latch iDevice, length N and iData.
  - LOW: oBusClock=0.
  - HIGH: oBusClock=1.
  - TAIL: oBusClock=0, select still asserted.
  - DONE: one cycle, then IDLE.
- Cycle after an accepted start:
  - oBusy=1, oBusSelect=iDevice, oBusMOSI = first byte, oBusClock=0.
  - Phase counter loads CLKDIV-1.
- Each phase lasts exactly CLKDIV cycles; the counter decrements, and the phase ends when it reaches 0.
- LOW→HIGH:
  - oBusClock rises.
  - iBusMISO sampled in that same clock edge and shifted into the receive register (rx <= {rx[23:0], MISO}).
- HIGH→LOW when bytes remain: oBusClock falls and oBusMOSI advances to the next byte in the same edge.
- HIGH→TAIL after byte N: oBusClock falls; oBusMOSI holds the last byte.
- TAIL→DONE:
  - oBusSelect=0, oBusMOSI=0.
  - oDone=1 and oBusy=0 in the same cycle.
  - oRead = rx, upper (4-N) bytes zero.
- Latency from accepting edge to oDone high: 2·N·CLKDIV + CLKDIV + 1 cycles (CLKDIV=4, N=4: 37).
- Back-to-back transfers: iStart asserted while oDone=1 is accepted (DONE behaves as IDLE for acceptance). Next oBusSelect assertion follows one cycle later; select is therefore deasserted for at least 1 cycle between transfers.
- iStart while oBusy=1 is ignored; no queuing and no error.
- iData, iDevice and iLength changes after acceptance have no effect.
- oInterrupt = iBusInterrupt delayed by SYNC_STAGES cycles. Independent of the FSM; active in every state.
- oBusSelect only changes while oBusClock=0.

Decomposition:
- Package eprisc_bus_pkg:
  - state encoding (IDLE, LOW, HIGH, TAIL, DONE)
  - SEL_NONE=2'd0
  - length decode constant (code 0 → 4)
  - word width 32, byte width 8
- Sub-module eprisc_bus_phase: loadable down-counter producing the phase-end tick, reloaded on start and on every phase change.
- Interrupt synchroniser stays inline.

Test Plan:
- Reset mid-transfer: reset asserted 10 cycles into an N=4 transfer → same delta: oBusSelect=0, oBusClock=0, oBusy=0; after release, IDLE and no oDone.
- Full word, CLKDIV=4: iBusMISO=8'hEA, start iDevice=1, iLength=0, iData=32'h12345678.
  - MOSI sequence 12,34,56,78, each held 8 cycles, changing only on falling oBusClock.
  - oDone at cycle 37; oRead=32'hEAEAEAEA.
- Short transfer: iLength=2, iData=32'hAABBCCDD, MISO 8'h5A then 8'hA5 (changed while oBusClock=0).
  - MOSI CC then DD.
  - oRead=32'h00005AA5; oDone at cycle 21.
- Illegal select: iStart with iDevice=0 → oError pulses one cycle, oBusy stays 0, bus pins unchanged.
- Back-to-back: iStart held high across oDone → second transfer accepted in the oDone cycle.
  - oBusSelect low exactly 1 cycle between transfers.
  - iStart pulses during oBusy ignored (exactly 2 oDone pulses total).
- Interrupt: iBusInterrupt 0→1 → oInterrupt rises exactly 2 cycles later, whether idle or mid-transfer.
